// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
//   Shared definitions for the bit-serial subtractor: FSM state encodings and
//   the signed-overflow helper used when SERIAL_SUB_OVF_EN is defined.
// ---------------------------------------------------------------------------
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Two's-complement overflow of a - b: operands differ in sign and the
  // result sign differs from the minuend sign.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb,
                                    input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_sub_fs_cell.sv
// ---------------------------------------------------------------------------
// fs_cell
//   Combinational one-bit full subtractor: d = x - y - bi, bo = borrow out.
// Ports
//   x   in  minuend bit
//   y   in  subtrahend bit
//   bi  in  borrow in
//   d   out difference bit
//   bo  out borrow out
// ---------------------------------------------------------------------------
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub.sv
// ---------------------------------------------------------------------------
// serial_sub
//   Bit-serial subtractor: diff = a - b - bin over WIDTH bits, LSB first, one
//   bit per clock through a single fs_cell.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request, honoured only when not busy
//   a, b   in   [WIDTH-1:0] operands, captured on an accepted start
//   bin    in   borrow-in, captured on an accepted start
//   busy   out  high while bits are shifting
//   done   out  one-cycle pulse, d/bout (and ovf) valid
//   d      out  [WIDTH-1:0] difference, held until the next completion
//   bout   out  final borrow-out, held with d
//   ovf    out  signed overflow, present only with SERIAL_SUB_OVF_EN
//
// Handshake: a start seen high at a clock edge while in IDLE or DONE is
// accepted on that edge; busy is high for exactly WIDTH cycles afterwards,
// then done pulses for one cycle with the result already on d/bout. A start
// high during busy is ignored and the operands are not re-sampled.
//
// Build option: define SERIAL_SUB_OVF_EN to add the ovf port and the two
// operand-MSB flops behind it.
// ---------------------------------------------------------------------------
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  // Minuend shifts out at bit 0 while difference bits shift in at the top,
  // so after WIDTH shifts this register holds the full difference.
  logic [WIDTH-1:0] ad_sh;
  logic [WIDTH-1:0] ad_sh_nxt;
  logic [WIDTH-1:0] b_sh;
  logic             br;
  logic             cell_d;
  logic             cell_bo;
  logic             accept;
  logic             last;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  fs_cell u_cell (
    .x  (ad_sh[0]),
    .y  (b_sh[0]),
    .bi (br),
    .d  (cell_d),
    .bo (cell_bo)
  );

  generate
    if (WIDTH == 1) begin : g_w1
      assign ad_sh_nxt = cell_d;
    end else begin : g_wn
      assign ad_sh_nxt = {cell_d, ad_sh[WIDTH-1:1]};
    end
  endgenerate

  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last   = (state == ST_SHIFT) && (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = start ? ST_SHIFT : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ad_sh <= '0;
      b_sh  <= '0;
      br    <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        ad_sh <= a;
        b_sh  <= b;
        br    <= bin;
        cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
`endif
      end else if (state == ST_SHIFT) begin
        ad_sh <= ad_sh_nxt;
        b_sh  <= b_sh >> 1;
        br    <= cell_bo;
        cnt   <= cnt + CNT_W'(1);
        // Results move to the outputs only on the edge entering DONE.
        if (last) begin
          d    <= ad_sh_nxt;
          bout <= cell_bo;
`ifdef SERIAL_SUB_OVF_EN
          ovf  <= ovf_calc(a_msb, b_msb, ad_sh_nxt[WIDTH-1]);
`endif
        end
      end
    end
  end

endmodule
